// File: rtl/xform_pkg.sv
// Shared types for the vertex transform issuer.
// Fixed-point words, vectors, matrices and FSM states.
package xform_pkg;

  localparam int XF_DW   = 24;
  localparam int XF_FRAC = 12;
  localparam int XF_AW   = 10;

  typedef logic [XF_DW-1:0] fixed_t;
  typedef fixed_t [3:0]     vec4_t;
  typedef vec4_t  [3:0]     mat4_t;

  localparam fixed_t FIX_ONE = fixed_t'(1) << XF_FRAC;

  typedef enum logic [2:0] {
    XS_IDLE  = 3'd0,
    XS_LOAD  = 3'd1,
    XS_ISSUE = 3'd2,
    XS_DRAIN = 3'd3,
    XS_DONE  = 3'd4
  } issuer_state_e;

endpackage

// File: rtl/vertex_xform_issuer_fifo.sv
// Synchronous FIFO holding returned clip-space vertices.
// Pointers wrap naturally; depth must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];
  localparam logic [AW:0] C_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] P_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DEPTH_L);
  assign count   = cnt_q;
  assign rdata   = mem_q[rptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage array, written on accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + P_ONE;
      if (do_pop)  rptr_q <= rptr_q + P_ONE;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + C_ONE;
        2'b01:   cnt_q <= cnt_q - C_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/vertex_xform_issuer.sv
// Batch sequencer feeding the 4x4 matrix-vector multiplier.
// Credits cover results in flight so the FIFO never overflows.
module vertex_xform_issuer
  import xform_pkg::*;
#(
  parameter int DATAWIDTH  = 24,
  parameter int FRACBITS   = 12,
  parameter int ADDRWIDTH  = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [3:0][3:0][DATAWIDTH-1:0]      mvp,
  input  logic [ADDRWIDTH-1:0]                num_vertices,
  output logic                                vert_rd_en,
  output logic [ADDRWIDTH-1:0]                vert_addr,
  input  logic [2:0][DATAWIDTH-1:0]           vert_data,
  output logic [3:0][3:0][DATAWIDTH-1:0]      A,
  output logic [3:0][DATAWIDTH-1:0]           x,
  output logic                                x_dv,
  input  logic [3:0][DATAWIDTH-1:0]           y_in,
  input  logic                                y_dv,
  output logic [3:0][DATAWIDTH-1:0]           out_vertex,
  output logic [ADDRWIDTH-1:0]                out_index,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = 4 * DATAWIDTH + ADDRWIDTH;

  localparam logic [2:0] ST_IDLE  = XS_IDLE;
  localparam logic [2:0] ST_LOAD  = XS_LOAD;
  localparam logic [2:0] ST_ISSUE = XS_ISSUE;
  localparam logic [2:0] ST_DRAIN = XS_DRAIN;
  localparam logic [2:0] ST_DONE  = XS_DONE;

  localparam logic [CW:0] DEPTH_L = FIFO_DEPTH[CW:0];
  localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [ADDRWIDTH-1:0] A_ONE =
    {{(ADDRWIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATAWIDTH-1:0] ONE =
    {{(DATAWIDTH-1){1'b0}}, 1'b1} << FRACBITS;

  logic [2:0]                       state_q, state_d;
  logic [3:0][3:0][DATAWIDTH-1:0]   a_q;
  logic [ADDRWIDTH-1:0]             n_q;
  logic [ADDRWIDTH-1:0]             issue_q, issue_d;
  logic [ADDRWIDTH-1:0]             tag_q, tag_d;
  logic [ADDRWIDTH-1:0]             retire_q, retire_d;
  logic [CW-1:0]                    infl_q, infl_d;
  logic                             x_dv_q;

  logic [FW-1:0]                    f_rdata;
  logic [CW-1:0]                    f_cnt;
  logic                             f_empty;
  logic                             f_full;
  logic                             pop;
  logic [CW:0]                      used;
  logic                             credit_ok;
  logic                             rd_en;
  logic                             last_rd;

  assign used      = {1'b0, infl_q} + {1'b0, f_cnt};
  assign credit_ok = (used < DEPTH_L);
  assign rd_en     = (state_q == ST_ISSUE) &&
                     (issue_q < n_q) && credit_ok;
  assign last_rd   = rd_en && (issue_q == n_q - A_ONE);
  assign pop       = !f_empty && out_ready;

  assign vert_rd_en = rd_en;
  assign vert_addr  = issue_q;
  assign A          = a_q;
  assign x_dv       = x_dv_q;
  assign x          = x_dv_q ? {ONE, vert_data} : '0;
  assign out_valid  = !f_empty;
  assign out_vertex = f_empty ? '0 : f_rdata[FW-1:ADDRWIDTH];
  assign out_index  = f_empty ? '0 : f_rdata[ADDRWIDTH-1:0];
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (y_dv),
    .wdata ({y_in, tag_q}),
    .pop   (pop),
    .rdata (f_rdata),
    .count (f_cnt),
    .empty (f_empty),
    .full  (f_full)
  );

  // Next-state, index and credit counter logic.
  always_comb begin
    state_d  = state_q;
    issue_d  = issue_q;
    tag_d    = y_dv ? tag_q + A_ONE : tag_q;
    retire_d = pop ? retire_q + A_ONE : retire_q;
    infl_d   = infl_q;
    unique case ({rd_en, y_dv})
      2'b10:   infl_d = infl_q + C_ONE;
      2'b01:   infl_d = infl_q - C_ONE;
      default: infl_d = infl_q;
    endcase
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        issue_d  = '0;
        tag_d    = '0;
        retire_d = '0;
        state_d  = (n_q == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (rd_en)   issue_d = issue_q + A_ONE;
        if (last_rd) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (retire_d == n_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, matrix capture and issue-valid delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      n_q      <= '0;
      issue_q  <= '0;
      tag_q    <= '0;
      retire_q <= '0;
      infl_q   <= '0;
      x_dv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      issue_q  <= issue_d;
      tag_q    <= tag_d;
      retire_q <= retire_d;
      infl_q   <= infl_d;
      x_dv_q   <= rd_en;
      if (state_q == ST_IDLE && start) begin
        a_q <= mvp;
        n_q <= num_vertices;
      end
    end
  end

  // Protocol guards: results only while busy, never into a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(y_dv && f_full && !pop))
        else $error("result pushed into full fifo");
      assert (!(y_dv && state_q == ST_IDLE))
        else $error("result returned while idle");
    end
  end

endmodule
